average_mem_rd_responder: RTL and testbench
===========================================

AVERAGE_MEM_RD_RESPONDER -- requirements
Module: average_mem_rd_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h0, byte address of memory window start (64-byte aligned).
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, log2 of window depth in 512-bit words (default 256 words, 16 KiB).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port memory_channels_ar_channel_rsc_dat  in  97  AR beat: [63:0] addr, [71:64] len, [74:72] size, [76:75] burst, [80:77] id, [96:81] lock/cache/prot/qos/region (ignored).
REQ-006 SHALL have port memory_channels_ar_channel_rsc_vld  in  1  AR valid.
REQ-007 SHALL have port memory_channels_ar_channel_rsc_rdy  out  1  AR ready.
REQ-008 SHALL have port memory_channels_r_channel_rsc_dat  out  519  R beat: [511:0] data, [513:512] resp, [514] last, [518:515] id.
REQ-009 SHALL have port memory_channels_r_channel_rsc_vld  out  1  R valid.
REQ-010 SHALL have port memory_channels_r_channel_rsc_rdy  in  1  R ready.
REQ-011 SHALL have port ld_en  in  1  preload write strobe.
REQ-012 SHALL have port ld_addr  in  DEPTH_LOG2  preload word index.
REQ-013 SHALL have port ld_data  in  512  preload word.
REQ-014 SHALL have port err_count  out  16  count of bursts containing any non-OKAY beat.

Function
REQ-015 SHALL hold 2^DEPTH_LOG2 x 512-bit dual-port storage; ld_en writes ld_data at ld_addr every cycle regardless of FSM state.
REQ-016 SHALL read first on same-index collision: a read in the same cycle as a write to that index returns the old word.
REQ-017 SHALL implement FSM IDLE -> FETCH -> SEND; IDLE: ar_rdy=1; AR handshake (vld&rdy) latches addr/len/size/burst/id, beat counter=0, -> FETCH.
REQ-018 SHALL in FETCH (ar_rdy=0, r_vld=0) issue storage read of current index; next cycle -> SEND with r_vld=1.
REQ-019 SHALL in SEND hold r_vld=1 and r_dat stable until r_rdy; on handshake: if last -> IDLE, else advance address, counter+1, -> FETCH.
REQ-020 SHALL give latency: AR handshake at cycle T -> first r_vld at T+2; with r_rdy held high, beats at T+2, T+4, ...; ar_rdy=1 in the cycle after the last R handshake.
REQ-021 SHALL support one outstanding burst; no AR accepted outside IDLE.
REQ-022 SHALL issue len+1 beats (1..256); last=1 only on beat len; id copied to every beat.
REQ-023 SHALL advance address by 64 per beat for burst=INCR (01); burst=FIXED (00) repeats the same address.
REQ-024 SHALL flag SLVERR (2'b10) on all beats, data 0, when size!=3'b110, burst is 10/11, or addr[5:0]!=0; full len+1 beats still issued.
REQ-025 SHALL flag DECERR (2'b11), data 0, per beat whose address is < BASE_ADDR or >= BASE_ADDR+64*2^DEPTH_LOG2 (incl. INCR running off window end); SLVERR takes priority over DECERR.
REQ-026 SHALL return OKAY (2'b00) with stored word at index (addr-BASE_ADDR)>>6 for all other beats.
REQ-027 SHALL increment err_count once per burst on its last handshake if any beat was non-OKAY; saturate at 16'hFFFF.
REQ-028 SHALL use 64-bit address arithmetic; no wrap at 2^64 within a burst (beats above max are DECERR).

Reset
REQ-029 SHALL, in any cycle rst=1: FSM->IDLE, ar_rdy=0, r_vld=0, r_dat=0, err_count=0; ar_rdy=1 from the first cycle after rst deasserts.
REQ-030 SHALL abandon an in-flight burst on rst with no further beats; storage contents are not reset and preload is ignored while rst=1.

Verification
REQ-031 SHALL cover: preload idx0..3 = 1,2,3,4; AR addr=BASE, len=3, INCR, size=6, id=5, r_rdy=1 -> 4 beats data 1..4 at T+2/4/6/8, resp 00, id 5, last on 4th only.
REQ-032 SHALL cover: AR addr=BASE+64*(2^DEPTH_LOG2-2), len=3 INCR -> beats 1-2 OKAY, beats 3-4 DECERR data 0; err_count 0->1.
REQ-033 SHALL cover: AR size=5, len=1 -> 2 SLVERR beats, data 0; AR addr=BASE+4 -> SLVERR; err_count +1 each.
REQ-034 SHALL cover: r_rdy low 5 cycles during beat 2 -> r_dat/r_vld stable; ar_rdy stays 0; no beat lost or duplicated.
REQ-035 SHALL cover: ld_en to idx1 in the FETCH cycle of beat idx1 -> old value returned; next burst reads new value.
REQ-036 SHALL cover: rst=1 after beat 2 of a len=7 burst -> r_vld=0, err_count=0 next cycle, ar_rdy=1 after release, new burst returns correct data.

Source files
------------

// File: rtl/average_mem_rd_responder.sv
// AXI-style single-outstanding read responder backed by a preloadable 512-bit word store.
// Each R beat takes one fetch cycle and one send cycle; out-of-window or malformed beats are error-flagged.
module average_mem_rd_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [96:0]           memory_channels_ar_channel_rsc_dat,
  input  logic                  memory_channels_ar_channel_rsc_vld,
  output logic                  memory_channels_ar_channel_rsc_rdy,
  output logic [518:0]          memory_channels_r_channel_rsc_dat,
  output logic                  memory_channels_r_channel_rsc_vld,
  input  logic                  memory_channels_r_channel_rsc_rdy,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [511:0]          ld_data,
  output logic [15:0]           err_count
);

  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;
  localparam logic [64:0] WinEnd = {1'b0, BASE_ADDR} + (65'd64 << DEPTH_LOG2);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;
  localparam logic [1:0] BurstIncr  = 2'b01;

  typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [511:0]          r_mem [Depth];
  logic [511:0]          r_rd_word;
  logic [63:0]           r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [3:0]            r_id;
  logic [7:0]            r_cnt;
  logic                  r_ovf;
  logic                  r_err_any;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic                  r_vld;
  logic [15:0]           r_err_count;

  logic                  w_ar_rdy;
  logic                  w_ar_hs;
  logic                  w_r_vld;
  logic                  w_r_hs;
  logic                  w_slverr;
  logic                  w_decerr;
  logic [1:0]            w_resp;
  logic [63:0]           w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [64:0]           w_addr_inc;
  logic                  w_unused;

  assign w_ar_rdy = (r_state == StIdle) && !rst;
  assign w_ar_hs  = memory_channels_ar_channel_rsc_vld && w_ar_rdy;
  assign w_r_vld  = r_vld && !rst;
  assign w_r_hs   = w_r_vld && memory_channels_r_channel_rsc_rdy;

  // Alignment stays invariant across INCR steps, so checking the current address is enough.
  assign w_slverr = (r_size != 3'b110) || r_burst[1] || (r_addr[5:0] != 6'd0);
  // r_ovf marks an INCR burst that carried past 2^64; those beats are never in the window.
  assign w_decerr = r_ovf || (r_addr < BASE_ADDR) || ({1'b0, r_addr} >= WinEnd);
  assign w_resp   = w_slverr ? RespSlverr : (w_decerr ? RespDecerr : RespOkay);

  assign w_off      = r_addr - BASE_ADDR;
  assign w_idx      = w_off[DEPTH_LOG2+5:6];
  assign w_addr_inc = {1'b0, r_addr} + 65'd64;

  assign w_unused = ^{memory_channels_ar_channel_rsc_dat[96:81], w_off[63:DEPTH_LOG2+6],
                      w_off[5:0]};

  // Storage is never reset; the registered read gives read-first behaviour on collisions.
  always_ff @(posedge clk) begin
    if (ld_en && !rst) begin
      r_mem[ld_addr] <= ld_data;
    end
    if (r_state == StFetch) begin
      r_rd_word <= r_mem[w_idx];
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_ar_hs) w_state_next = StFetch;
      StFetch: w_state_next = StSend;
      StSend:  if (w_r_hs) w_state_next = r_last ? StIdle : StFetch;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_vld       <= 1'b0;
      r_resp      <= RespOkay;
      r_last      <= 1'b0;
      r_err_any   <= 1'b0;
      r_ovf       <= 1'b0;
      r_cnt       <= 8'd0;
      r_err_count <= 16'd0;
    end else begin
      r_state <= w_state_next;

      if (w_ar_hs) begin
        r_addr    <= memory_channels_ar_channel_rsc_dat[63:0];
        r_len     <= memory_channels_ar_channel_rsc_dat[71:64];
        r_size    <= memory_channels_ar_channel_rsc_dat[74:72];
        r_burst   <= memory_channels_ar_channel_rsc_dat[76:75];
        r_id      <= memory_channels_ar_channel_rsc_dat[80:77];
        r_cnt     <= 8'd0;
        r_ovf     <= 1'b0;
        r_err_any <= 1'b0;
      end

      if (r_state == StFetch) begin
        r_resp <= w_resp;
        r_last <= (r_cnt == r_len);
        r_vld  <= 1'b1;
        if (w_resp != RespOkay) begin
          r_err_any <= 1'b1;
        end
      end

      if (w_r_hs) begin
        r_vld <= 1'b0;
        if (r_last) begin
          if (r_err_any && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
          end
        end else begin
          r_cnt <= r_cnt + 8'd1;
          if (r_burst == BurstIncr) begin
            r_addr <= w_addr_inc[63:0];
            if (w_addr_inc[64]) begin
              r_ovf <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign memory_channels_ar_channel_rsc_rdy = w_ar_rdy;
  assign memory_channels_r_channel_rsc_vld  = w_r_vld;
  assign memory_channels_r_channel_rsc_dat  =
      w_r_vld ? {r_id, r_last, r_resp, (r_resp == RespOkay) ? r_rd_word : 512'd0} : 519'd0;
  assign err_count = rst ? 16'd0 : r_err_count;

endmodule

// File: tb/tb_average_mem_rd_responder.sv
// Randomised bench for average_mem_rd_responder against a per-beat behavioural model.
module tb_average_mem_rd_responder;

  localparam logic [63:0] Base  = 64'h0000_0000_0001_0000;
  localparam int unsigned Dl    = 4;
  localparam int unsigned Words = 1 << Dl;

  logic          clk;
  logic          rst;
  logic [96:0]   ar_dat;
  logic          ar_vld;
  logic          ar_rdy;
  logic [518:0]  r_dat;
  logic          r_vld;
  logic          r_rdy;
  logic          ld_en;
  logic [Dl-1:0] ld_addr;
  logic [511:0]  ld_data;
  logic [15:0]   err_count;

  average_mem_rd_responder #(
    .BASE_ADDR (Base),
    .DEPTH_LOG2(Dl)
  ) dut (
    .clk                                (clk),
    .rst                                (rst),
    .memory_channels_ar_channel_rsc_dat (ar_dat),
    .memory_channels_ar_channel_rsc_vld (ar_vld),
    .memory_channels_ar_channel_rsc_rdy (ar_rdy),
    .memory_channels_r_channel_rsc_dat  (r_dat),
    .memory_channels_r_channel_rsc_vld  (r_vld),
    .memory_channels_r_channel_rsc_rdy  (r_rdy),
    .ld_en                              (ld_en),
    .ld_addr                            (ld_addr),
    .ld_data                            (ld_data),
    .err_count                          (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp;
  int           n_bad;
  logic [511:0] mdl_mem [Words];
  logic [15:0]  mdl_err;

  task automatic chk(input string tag, input logic [518:0] got, input logic [518:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Expected beat k of a burst, straight from the address/size/burst rules.
  function automatic logic [518:0] exp_beat(input logic [63:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input logic [3:0] id, input int k);
    logic [64:0]  a;
    logic [64:0]  off;
    logic [1:0]   resp;
    logic [511:0] d;
    a = {1'b0, addr};
    if (burst == 2'b01) a = a + 65'(k) * 65'd64;
    resp = 2'b00;
    d    = '0;
    if (size != 3'd6 || burst[1] || addr[5:0] != 6'd0) begin
      resp = 2'b10;
    end else if (a < {1'b0, Base} || a >= {1'b0, Base} + 65'(Words) * 65'd64) begin
      resp = 2'b11;
    end else begin
      off = (a - {1'b0, Base}) / 65'd64;
      d   = mdl_mem[off[Dl-1:0]];
    end
    return {id, (k == int'(len)), resp, d};
  endfunction

  task automatic preload(input int idx, input logic [511:0] val);
    ld_en   = 1'b1;
    ld_addr = idx[Dl-1:0];
    ld_data = val;
    step();
    ld_en = 1'b0;
    mdl_mem[idx] = val;
  endtask

  // ld_cyc >= 0 writes ld_val to ld_idx in that cycle after the AR handshake;
  // rst_after >= 0 asserts reset once that many beats have been accepted.
  task automatic run_burst(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int stall_beat,
                           input int stall_cyc, input int ld_cyc, input int ld_idx,
                           input logic [511:0] ld_val, input int rst_after);
    logic [518:0] exp_q [$];
    bit any_err = 0;
    bit seen    = 0;
    bit hs;
    int guard   = 0;
    int cyc     = 1;
    int beat    = 0;
    int exp_cyc = 2;
    int stall_left = stall_cyc;
    for (int k = 0; k <= int'(len); k++) begin
      exp_q.push_back(exp_beat(addr, len, size, burst, id, k));
      if (exp_q[k][513:512] != 2'b00) any_err = 1;
    end
    ar_dat = {16'($urandom()), id, burst, size, len, addr};
    ar_vld = 1'b1;
    while (!ar_rdy && guard < 50) begin
      step();
      guard++;
    end
    if (!ar_rdy) begin
      chk("ar_rdy_timeout", ar_rdy, 1);
      ar_vld = 1'b0;
      return;
    end
    step();
    ar_vld = 1'b0;
    ar_dat = {$urandom(), $urandom(), $urandom(), 1'b0};
    while (beat <= int'(len) && cyc < 500) begin
      ld_en   = (cyc == ld_cyc);
      ld_addr = ld_idx[Dl-1:0];
      ld_data = ld_val;
      if (rst_after >= 0 && beat == rst_after) begin
        rst     = 1'b1;
        r_rdy   = 1'b1;
        ld_en   = 1'b1;
        ld_addr = 2;
        ld_data = rand512();
        #1;
        chk("rst_r_vld", r_vld, 0);
        chk("rst_ar_rdy", ar_rdy, 0);
        chk("rst_err_count", err_count, 0);
        step();
        chk("rst_r_vld_next", r_vld, 0);
        chk("rst_r_dat_next", r_dat, 0);
        chk("rst_err_next", err_count, 0);
        step();
        rst   = 1'b0;
        ld_en = 1'b0;
        #1;
        mdl_err = 0;
        chk("rst_rel_ar_rdy", ar_rdy, 1);
        step();
        chk("rst_no_more_beats", r_vld, 0);
        return;
      end
      if (r_vld) begin
        if (!seen) begin
          chk("r_latency", cyc, exp_cyc);
          seen = 1;
        end
        chk("r_dat", r_dat, exp_q[beat]);
      end
      if (r_vld && beat == stall_beat && stall_left > 0) begin
        r_rdy = 1'b0;
        stall_left--;
        chk("ar_rdy_busy", ar_rdy, 0);
      end else begin
        r_rdy = 1'b1;
      end
      hs = r_vld && r_rdy;
      step();
      if (hs) begin
        beat++;
        exp_cyc = cyc + 2;
        seen    = 0;
      end
      cyc++;
    end
    ld_en = 1'b0;
    if (beat <= int'(len)) chk("r_beat_timeout", beat, int'(len) + 1);
    chk("ar_rdy_after", ar_rdy, 1);
    chk("r_vld_after", r_vld, 0);
    if (ld_cyc >= 0) mdl_mem[ld_idx] = ld_val;
    if (any_err && mdl_err != 16'hFFFF) mdl_err++;
    chk("err_count", err_count, mdl_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    logic [7:0]  ln;
    logic [2:0]  sz;
    logic [1:0]  bu;
    int          sel;
    n_cmp   = 0;
    n_bad   = 0;
    mdl_err = 0;
    rst     = 1'b1;
    ar_vld  = 1'b0;
    ar_dat  = '0;
    r_rdy   = 1'b0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    step();
    step();
    chk("reset_r_vld", r_vld, 0);
    chk("reset_ar_rdy", ar_rdy, 0);
    chk("reset_r_dat", r_dat, 0);
    chk("reset_err_count", err_count, 0);
    step();
    rst = 1'b0;
    #1;
    chk("reset_rel_ar_rdy", ar_rdy, 1);

    for (int i = 0; i < int'(Words); i++) preload(i, rand512());
    for (int i = 0; i < 4; i++) preload(i, 512'(i + 1));

    // Basic INCR burst over idx0..3.
    run_burst(Base, 8'd3, 3'd6, 2'b01, 4'd5, -1, 0, -1, 0, '0, -1);
    // Runs off the window end after two beats.
    run_burst(Base + 64 * (Words - 2), 8'd3, 3'd6, 2'b01, 4'd2, -1, 0, -1, 0, '0, -1);
    // Bad size, then misaligned address.
    run_burst(Base, 8'd1, 3'd5, 2'b01, 4'd7, -1, 0, -1, 0, '0, -1);
    run_burst(Base + 4, 8'd0, 3'd6, 2'b01, 4'd1, -1, 0, -1, 0, '0, -1);
    // Back-pressure on beat 2.
    run_burst(Base, 8'd3, 3'd6, 2'b01, 4'd11, 1, 5, -1, 0, '0, -1);
    // Write to idx1 during the fetch of beat idx1, then read it back.
    run_burst(Base, 8'd1, 3'd6, 2'b01, 4'd3, -1, 0, 3, 1, rand512(), -1);
    run_burst(Base + 64, 8'd0, 3'd6, 2'b01, 4'd3, -1, 0, -1, 0, '0, -1);
    // Reset mid-burst, then a clean burst.
    run_burst(Base, 8'd7, 3'd6, 2'b01, 4'd9, -1, 0, -1, 0, '0, 2);
    run_burst(Base, 8'd7, 3'd6, 2'b01, 4'd9, -1, 0, -1, 0, '0, -1);
    // FIXED, below-base, reserved burst type, and running past 2^64.
    run_burst(Base + 64 * 5, 8'd3, 3'd6, 2'b00, 4'd4, -1, 0, -1, 0, '0, -1);
    run_burst(Base - 64, 8'd1, 3'd6, 2'b01, 4'd6, -1, 0, -1, 0, '0, -1);
    run_burst(Base, 8'd1, 3'd6, 2'b10, 4'd8, -1, 0, -1, 0, '0, -1);
    run_burst(64'hFFFF_FFFF_FFFF_FFC0, 8'd2, 3'd6, 2'b01, 4'd15, -1, 0, -1, 0, '0, -1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) preload($urandom_range(0, Words - 1), rand512());
      sel = $urandom_range(0, Words + 3);
      a   = Base + 64'(sel) * 64 - 64'd128;
      if ($urandom_range(0, 9) == 0) a = a + 64'($urandom_range(1, 63));
      ln = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(10, 40)) : 8'($urandom_range(0, 9));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd6;
      sel = $urandom_range(0, 9);
      bu = (sel < 6) ? 2'b01 : (sel < 9) ? 2'b00 : 2'($urandom_range(2, 3));
      run_burst(a, ln, sz, bu, 4'($urandom()), $urandom_range(0, ln), $urandom_range(0, 3),
                -1, 0, '0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
